mask_decompressor: RTL and testbench
====================================

Name: mask_decompressor

Overview:
- Inverse of the mask-driven prefix-sum compaction path.
- Accepts a VEC_LEN-bit occupancy mask, then a packed stream of nonzero elements in LANES-wide beats.
- Scatters each packed element back to the position of its corresponding set mask bit and emits one dense VEC_LEN-element vector.
- Zero-filled positions are 0. Sits on the redundancy-controller output side, restoring dense operands after zero-skipping.

Parameters:
VEC_LEN, 128, mask width and dense output element count; must be a multiple of LANES
DATA_W, 8, bits per element
LANES, 8, packed elements per input beat
CNT_W, 8, width of popcount and internal exclusive prefix sums; must satisfy 2^CNT_W > VEC_LEN

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
mask_valid  input  1  mask offered
mask_ready  output  1  mask accepted when mask_valid && mask_ready
mask  input  VEC_LEN  bit p=1 means dense position p holds a packed element
din_valid  input  1  packed beat offered
din_ready  output  1  beat accepted when din_valid && din_ready
din  input  LANES*DATA_W  lane j at din[j*DATA_W +: DATA_W]; lane 0 is the earliest element
dout_valid  output  1  dense vector valid
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
dout  output  VEC_LEN*DATA_W  element p at dout[p*DATA_W +: DATA_W]
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset outcome:
  - State returns to IDLE; the write pointer k is cleared to 0.
  - mask_ready=1; din_ready=0; dout_valid=0; dout=0; busy=0.
  - Packed buffer contents are don't-care.
  - Reset in any state, including mid-FILL or while OUT is stalled, aborts the transfer. The partial vector is never emitted.
- States: IDLE, FILL, GATHER, OUT.
- IDLE:
  - mask_ready=1.
  - On mask handshake, register the mask and its exclusive prefix sums psum[p] (the number of set bits below p, CNT_W bits each).
  - Register the total count N = popcount(mask).
  - Clear k to 0.
  - Next state is FILL if N>0, otherwise GATHER.
- FILL:
  - din_ready=1, mask_ready=0.
  - On each beat handshake, write lane j into buf[k+j] for j=0..LANES-1, then k += LANES.
  - If k+LANES >= N at the accepting edge, next state is GATHER. Lanes landing at index >= N are ignored, and their values never reach dout.
  - din_valid low: hold state, no write.
- GATHER:
  - Exactly one cycle; din_ready=0.
  - Register dout[p] = mask[p] ? buf[psum[p]] : 0 for all p.
  - Next state is OUT.
- OUT:
  - dout_valid=1; dout held stable while dout_ready=0.
  - On handshake, dout_valid drops next cycle and state goes to IDLE. dout keeps its last value, but only dout_valid qualifies it.
  - mask_ready=0 throughout OUT; no overlap with the next mask.
- Latency:
  - Mask handshake at edge T with N>0 and the last beat accepted at edge L: dout_valid rises after edge L+1.
  - N=0: dout_valid rises after edge T+1.
  - Minimum beats per vector: ceil(N/LANES). Full mask: VEC_LEN/LANES = 16 beats.
- Arithmetic:
  - psum and k are CNT_W unsigned values; k never exceeds VEC_LEN.
  - The buffer index is always < N, so there is no wrap.
- Stray inputs: din_valid outside FILL and mask_valid outside IDLE are ignored, with no state change.

Test Plan:
- Sparse mask, one beat: mask bits {0,1,4} set (N=3), din lanes 0..7 = 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> dout[0]=0x11, dout[1]=0x22, dout[4]=0x33, all other 124 elements 0x00; dout_valid rises 2 edges after the beat.
- Full mask (128 ones), 16 beats carrying 0x00..0x7F in order, with din_valid dropped for 3 cycles after beat 5 -> dout[p]=p for all p; din_ready stays high during the gap; exactly 16 beats consumed.
- Zero mask -> din_ready never asserts; dout_valid rises the cycle after GATHER; dout all zero.
- Repeating-pattern mask (each 32-bit quarter = 32'b01001011101000100100011101011101, N=64), 8 beats with element values 1..64 -> dout at the n-th set bit (counted from bit 0) equals n, all cleared positions 0.
- Backpressure: hold dout_ready=0 for 5 cycles in OUT -> dout_valid and dout stable, mask_ready=0, and a mask presented meanwhile is not accepted until the cycle after the dout handshake.
- Reset asserted after 3 of 16 beats of a full-mask transfer -> next cycle IDLE, mask_ready=1, dout_valid=0; a subsequent clean transfer with N=3 produces the correct vector, uncontaminated by the aborted data.

Source files
------------

// File: rtl/mask_decompressor.sv
// Scatters a packed stream of nonzero elements back to the dense positions
// given by an occupancy mask, producing one zero-filled VEC_LEN vector.
//
// state  | meaning
// IDLE   | waiting for a mask
// FILL   | accepting packed beats into the buffer
// GATHER | one cycle: scatter buffer to dense positions
// OUT    | presenting dense vector until consumed
module mask_decompressor #(
  parameter int VEC_LEN = 128,
  parameter int DATA_W  = 8,
  parameter int LANES   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mask_valid,
  output logic                      mask_ready,
  input  logic [VEC_LEN-1:0]        mask,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [LANES*DATA_W-1:0]   din,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [VEC_LEN*DATA_W-1:0] dout,
  output logic                      busy
);

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [1:0] {IDLE, FILL, GATHER, OUT} state_t;

  state_t                    state_q, state_d;
  logic [VEC_LEN-1:0]        mask_q, mask_d;
  logic [CNT_W-1:0]          psum_q [VEC_LEN];
  logic [CNT_W-1:0]          psum_d [VEC_LEN];
  logic [CNT_W-1:0]          n_q, n_d;
  logic [CNT_W-1:0]          k_q, k_d;
  logic [DATA_W-1:0]         buf_q [VEC_LEN];
  logic [DATA_W-1:0]         buf_d [VEC_LEN];
  logic [VEC_LEN*DATA_W-1:0] dout_q, dout_d;
  logic                      mask_ready_q, mask_ready_d;
  logic                      din_ready_q, din_ready_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      busy_q, busy_d;

  logic [CNT_W-1:0]          acc;
  logic [CNT_W-1:0]          widx;
  logic [CNT_W:0]            k_end;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    psum_d  = psum_q;
    n_d     = n_q;
    k_d     = k_q;
    buf_d   = buf_q;
    dout_d  = dout_q;
    acc     = '0;
    widx    = '0;
    k_end   = {1'b0, k_q} + (CNT_W+1)'(LANES);

    case (state_q)
      IDLE: begin
        if (mask_valid) begin
          mask_d = mask;
          for (int p = 0; p < VEC_LEN; p++) begin
            psum_d[p] = acc;
            acc       = acc + CNT_W'(mask[p]);
          end
          n_d     = acc;
          k_d     = '0;
          state_d = (acc != '0) ? FILL : GATHER;
        end
      end
      FILL: begin
        if (din_valid) begin
          // lanes past the element count are padding and must not be stored
          for (int j = 0; j < LANES; j++) begin
            widx = k_q + CNT_W'(j);
            if (widx < n_q)
              buf_d[IDX_W'(widx)] = din[j*DATA_W +: DATA_W];
          end
          k_d = k_q + CNT_W'(LANES);
          if (k_end >= {1'b0, n_q})
            state_d = GATHER;
        end
      end
      GATHER: begin
        for (int p = 0; p < VEC_LEN; p++)
          dout_d[p*DATA_W +: DATA_W] = mask_q[p] ? buf_q[IDX_W'(psum_q[p])] : '0;
        state_d = OUT;
      end
      OUT: begin
        if (dout_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mask_ready_d = (state_d == IDLE);
    din_ready_d  = (state_d == FILL);
    dout_valid_d = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    mask_q <= mask_d;
    psum_q <= psum_d;
    buf_q  <= buf_d;
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      k_q          <= '0;
      dout_q       <= '0;
      mask_ready_q <= 1'b1;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      dout_q       <= dout_d;
      mask_ready_q <= mask_ready_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mask_ready = mask_ready_q;
  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mask_decompressor.sv
// Directed vector bench for mask_decompressor: table of masks/packed data with
// hand-computed dense results, plus sequences for backpressure and reset abort.
module tb_mask_decompressor;

  localparam int VEC_LEN = 128;
  localparam int DATA_W  = 8;
  localparam int LANES   = 8;
  localparam int CNT_W   = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      mask_valid;
  logic                      mask_ready;
  logic [VEC_LEN-1:0]        mask;
  logic                      din_valid;
  logic                      din_ready;
  logic [LANES*DATA_W-1:0]   din;
  logic                      dout_valid;
  logic                      dout_ready;
  logic [VEC_LEN*DATA_W-1:0] dout;
  logic                      busy;

  mask_decompressor #(
    .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask(mask),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                     name;
    logic [VEC_LEN-1:0]        mask;
    logic [VEC_LEN*DATA_W-1:0] elems;
    int                        gap_after;
    int                        gap_len;
    int                        stall;
    bit                        stray_mask;
    logic [VEC_LEN*DATA_W-1:0] exp_dout;
  } vec_t;

  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VEC_LEN*DATA_W-1:0] act,
                         input logic [VEC_LEN*DATA_W-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = -1;
      for (int p = VEC_LEN - 1; p >= 0; p--)
        if (act[p*DATA_W +: DATA_W] !== exp[p*DATA_W +: DATA_W]) first = p;
      $display("FAIL %s: element %0d got %02h expected %02h", name, first,
               act[first*DATA_W +: DATA_W], exp[first*DATA_W +: DATA_W]);
    end
  endtask

  // reference scatter: walk mask bits in order, consuming packed elements
  function automatic logic [VEC_LEN*DATA_W-1:0] scatter(input logic [VEC_LEN-1:0] m,
                                                        input logic [VEC_LEN*DATA_W-1:0] e);
    logic [VEC_LEN*DATA_W-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int p = 0; p < VEC_LEN; p++)
      if (m[p]) begin
        r[p*DATA_W +: DATA_W] = e[n*DATA_W +: DATA_W];
        n++;
      end
    return r;
  endfunction

  task automatic run_vec(input int v);
    logic [VEC_LEN*DATA_W-1:0] snap;
    string nm;
    int n, nb, to;
    nm = vecs[v].name;
    n  = $countones(vecs[v].mask);
    nb = (n + LANES - 1) / LANES;

    mask       = vecs[v].mask;
    mask_valid = 1'b1;
    to = 0;
    while (!mask_ready && to < 50) begin
      @(posedge clk); #1;
      to++;
    end
    chk_bit({nm, " mask_ready"}, mask_ready, 1'b1);
    @(posedge clk); #1;
    mask_valid = 1'b0;

    if (n == 0) begin
      chk_bit({nm, " din_ready gather"}, din_ready, 1'b0);
      chk_bit({nm, " dout_valid gather"}, dout_valid, 1'b0);
      chk_bit({nm, " busy gather"}, busy, 1'b1);
      @(posedge clk); #1;
      chk_bit({nm, " din_ready out"}, din_ready, 1'b0);
      chk_bit({nm, " dout_valid T+1"}, dout_valid, 1'b1);
    end else begin
      for (int b = 0; b < nb; b++) begin
        din       = vecs[v].elems[b*LANES*DATA_W +: LANES*DATA_W];
        din_valid = 1'b1;
        chk_bit({nm, " din_ready beat"}, din_ready, 1'b1);
        @(posedge clk); #1;
        if (b + 1 == vecs[v].gap_after) begin
          din_valid = 1'b0;
          for (int g = 0; g < vecs[v].gap_len; g++) begin
            chk_bit({nm, " din_ready gap"}, din_ready, 1'b1);
            @(posedge clk); #1;
          end
        end
      end
      // stray beat offered after the last one must be ignored
      din       = '1;
      din_valid = 1'b1;
      chk_bit({nm, " din_ready after last"}, din_ready, 1'b0);
      chk_bit({nm, " dout_valid at L"}, dout_valid, 1'b0);
      @(posedge clk); #1;
      chk_bit({nm, " dout_valid L+1"}, dout_valid, 1'b1);
      din_valid = 1'b0;
    end

    chk_vec({nm, " dout"}, dout, vecs[v].exp_dout);
    snap = dout;
    if (vecs[v].stray_mask) begin
      mask       = '1;
      mask_valid = 1'b1;
    end
    for (int s = 0; s < vecs[v].stall; s++) begin
      @(posedge clk); #1;
      chk_bit({nm, " dout_valid stall"}, dout_valid, 1'b1);
      chk_bit({nm, " mask_ready stall"}, mask_ready, 1'b0);
      chk_vec({nm, " dout stable"}, dout, snap);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    mask_valid = 1'b0;
    chk_bit({nm, " dout_valid drop"}, dout_valid, 1'b0);
    chk_bit({nm, " mask_ready back"}, mask_ready, 1'b1);
    chk_bit({nm, " busy idle"}, busy, 1'b0);
    chk_vec({nm, " dout kept"}, dout, vecs[v].exp_dout);
  endtask

  initial begin
    reset      = 1'b1;
    mask_valid = 1'b0;
    mask       = '0;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b0;

    vecs[0].name = "sparse";
    vecs[0].mask = 128'h13;
    for (int i = 0; i < VEC_LEN; i++)
      vecs[0].elems[i*DATA_W +: DATA_W] = (i < 8) ? 8'((i + 1) * 17) : 8'hEE;
    vecs[0].gap_after = 0; vecs[0].gap_len = 0; vecs[0].stall = 0; vecs[0].stray_mask = 1'b0;
    vecs[0].exp_dout = '0;
    vecs[0].exp_dout[0*DATA_W +: DATA_W] = 8'h11;
    vecs[0].exp_dout[1*DATA_W +: DATA_W] = 8'h22;
    vecs[0].exp_dout[4*DATA_W +: DATA_W] = 8'h33;

    vecs[1].name = "full";
    vecs[1].mask = '1;
    for (int i = 0; i < VEC_LEN; i++) begin
      vecs[1].elems[i*DATA_W +: DATA_W]    = 8'(i);
      vecs[1].exp_dout[i*DATA_W +: DATA_W] = 8'(i);
    end
    vecs[1].gap_after = 5; vecs[1].gap_len = 3; vecs[1].stall = 0; vecs[1].stray_mask = 1'b0;

    vecs[2].name = "zero";
    vecs[2].mask = '0;
    vecs[2].elems = '1;
    vecs[2].gap_after = 0; vecs[2].gap_len = 0; vecs[2].stall = 0; vecs[2].stray_mask = 1'b0;
    vecs[2].exp_dout = '0;

    vecs[3].name = "pattern";
    vecs[3].mask = {4{32'b01001011101000100100011101011101}};
    for (int i = 0; i < VEC_LEN; i++)
      vecs[3].elems[i*DATA_W +: DATA_W] = (i < 64) ? 8'(i + 1) : 8'hCC;
    vecs[3].gap_after = 0; vecs[3].gap_len = 0; vecs[3].stall = 5; vecs[3].stray_mask = 1'b1;
    vecs[3].exp_dout = scatter(vecs[3].mask, vecs[3].elems);

    vecs[4].name = "post_reset";
    vecs[4].mask = '0;
    vecs[4].mask[2]   = 1'b1;
    vecs[4].mask[64]  = 1'b1;
    vecs[4].mask[127] = 1'b1;
    for (int i = 0; i < VEC_LEN; i++)
      vecs[4].elems[i*DATA_W +: DATA_W] = 8'h5A;
    vecs[4].elems[0*DATA_W +: DATA_W] = 8'hA1;
    vecs[4].elems[1*DATA_W +: DATA_W] = 8'hB2;
    vecs[4].elems[2*DATA_W +: DATA_W] = 8'hC3;
    vecs[4].gap_after = 0; vecs[4].gap_len = 0; vecs[4].stall = 1; vecs[4].stray_mask = 1'b0;
    vecs[4].exp_dout = '0;
    vecs[4].exp_dout[2*DATA_W +: DATA_W]   = 8'hA1;
    vecs[4].exp_dout[64*DATA_W +: DATA_W]  = 8'hB2;
    vecs[4].exp_dout[127*DATA_W +: DATA_W] = 8'hC3;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_bit("reset mask_ready", mask_ready, 1'b1);
    chk_bit("reset din_ready", din_ready, 1'b0);
    chk_bit("reset dout_valid", dout_valid, 1'b0);
    chk_bit("reset busy", busy, 1'b0);
    chk_vec("reset dout", dout, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) run_vec(v);
    chk8("pattern first set bit", dout[0*DATA_W +: DATA_W], 8'h01);
    chk8("pattern bit 1 cleared", dout[1*DATA_W +: DATA_W], 8'h00);
    chk8("pattern last set bit", dout[126*DATA_W +: DATA_W], 8'h40);

    // abort a full-mask transfer after 3 beats
    mask       = '1;
    mask_valid = 1'b1;
    chk_bit("abort mask_ready", mask_ready, 1'b1);
    @(posedge clk); #1;
    mask_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      din       = {8{8'(8'hE0 + b)}};
      din_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk_bit("abort busy before reset", busy, 1'b1);
    chk_bit("abort din_ready before reset", din_ready, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    din_valid = 1'b0;
    chk_bit("abort mask_ready", mask_ready, 1'b1);
    chk_bit("abort dout_valid", dout_valid, 1'b0);
    chk_bit("abort din_ready", din_ready, 1'b0);
    chk_bit("abort busy", busy, 1'b0);
    chk_vec("abort dout", dout, '0);
    @(posedge clk); #1;
    chk_bit("abort no emit", dout_valid, 1'b0);

    run_vec(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
